uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised next-generation UART receiver for the microcontroller's UART peripheral.
- Adds runtime data length, 1/2 stop bits, 3-sample majority voting, and a 2-flop input synchroniser.
- Adds break detection and a first-word-fall-through receive FIFO carrying per-frame error flags, with a sticky overrun flag.
- Sits between the RX pad and the peripheral bus register interface.

Parameters:
- MAX_DATA_W, 9, maximum data bits per frame; legal 5..9.
- PRESC_W, 8, width of the Prescale input.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial input, asynchronous; idles high.
- Prescale  in  PRESC_W  clocks per bit; legal values are even and at least 8.
- DATA_LEN  in  4  data bits per frame; legal range 5..MAX_DATA_W.
- PAR_EN  in  1  1 = a parity bit follows the data.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  1 = two stop bits.
- RD_EN  in  1  pop the FIFO head.
- CLR_OVR  in  1  single-cycle pulse that clears OVERRUN.
- RD_DATA  out  MAX_DATA_W  head data, LSB = first received bit, zero-extended.
- RD_PERR  out  1  head frame had a parity error.
- RD_FERR  out  1  head frame had a framing error.
- RD_BRK  out  1  head frame is a break.
- FIFO_EMPTY  out  1  FIFO holds no frames.
- FIFO_FULL  out  1  FIFO holds FIFO_DEPTH frames.
- OVERRUN  out  1  sticky: a completed frame was dropped.

Behaviour:
- Reset:
  - State is IDLE and all counters are 0.
  - Synchroniser flops reset to 1.
  - FIFO is empty: FIFO_EMPTY=1, FIFO_FULL=0.
  - RD_* outputs read 0; OVERRUN=0.
- Synchroniser: all decisions use rx_s, which is RX_IN delayed by 2 flops.
- Edge counter:
  - Counts 0..Prescale-1 within each bit, then wraps to 0 and increments the bit counter.
  - Sample points are edges P/2-1, P/2 and P/2+1, where P = Prescale.
  - The sampled bit is the majority of the 3 samples.
- Configuration latch: DATA_LEN, PAR_EN, PAR_TYP, STOP2 and Prescale are latched in the cycle START is entered. Later changes affect the next frame only.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when rx_s==0. That cycle is edge 0 of the start bit.
  - START: at edge P/2+1, if the majority sample is 1 the start is a glitch -> IDLE, nothing is written. Otherwise -> DATA at the end of the bit.
  - DATA: shifts DATA_LEN bits LSB-first, then goes to PARITY if PAR_EN=1, else to STOP.
  - PARITY: perr = XOR(data bits, parity bit) != PAR_TYP.
  - STOP: one or two bits. ferr=1 if any stop-bit majority sample is 0.
  - The frame completes at edge P/2+1 of the last stop bit. The FIFO write happens on that clock edge, and the FSM moves to IDLE in the same cycle. This mid-bit resync allows back-to-back frames.
- Break detection: brk=1 when ferr=1, all data bits are 0, and the parity bit is 0 (if PAR_EN=1). perr and ferr are still reported alongside brk.
- FIFO behaviour:
  - Entry = {brk, ferr, perr, data}; the RD_* outputs show the head entry combinationally.
  - RD_EN while empty is ignored.
  - A write while full drops the frame and sets OVERRUN, unless RD_EN is asserted in the same cycle; then both the read and the write succeed and nothing is dropped.
  - Simultaneous read and write while not empty: occupancy is unchanged.
- OVERRUN: cleared by CLR_OVR. If CLR_OVR and a new overrun occur in the same cycle, set wins.
- Pointers: wrap modulo FIFO_DEPTH. FIFO_FULL/FIFO_EMPTY are derived from an occupancy count of width log2(FIFO_DEPTH)+1.
- Illegal configuration: if DATA_LEN is outside 5..MAX_DATA_W, the latched value is clamped into that range.
- Reset mid-frame: the partial frame is discarded and the FSM returns to IDLE.

Test Plan:
- Prescale=8, DATA_LEN=8, no parity, 1 stop, send 0xA5 -> one entry, RD_DATA=0x0A5, all flags 0, FIFO_EMPTY falls about 10 bit times after the start edge.
- 3-clock low pulse on idle RX_IN -> no FIFO write, FSM back in IDLE, FIFO_EMPTY stays 1.
- DATA_LEN=7, PAR_EN=1, PAR_TYP=1, send 0x55 with a wrong parity bit -> RD_DATA=0x055, RD_PERR=1, RD_FERR=0.
- MAX_DATA_W=9, DATA_LEN=9, STOP2=1, second stop bit driven 0 -> RD_DATA=0x1FF, RD_FERR=1, RD_BRK=0.
- Hold RX_IN low for 12 bit times, DATA_LEN=8 -> RD_DATA=0, RD_FERR=1, RD_BRK=1.
- Five back-to-back frames 0x01..0x05 with no reads (depth 4) -> FIFO_FULL=1, OVERRUN=1, reads return 0x01..0x04; CLR_OVR clears OVERRUN; a 6th frame received while full with RD_EN asserted at the write cycle -> no overrun.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// Receive-side register bus of the UART receiver.
// Carries the FIFO pop and overrun-clear strobes from the peripheral bus.
// Carries the FIFO head entry, the FIFO status and the sticky overrun flag back.
//   master : bus side (drives RD_EN and CLR_OVR)
//   slave  : receiver side (drives the head data, flags and status)
interface uart_rx_param_if #(
  parameter int MAX_DATA_W = 9
);
  logic                  RD_EN;
  logic                  CLR_OVR;
  logic [MAX_DATA_W-1:0] RD_DATA;
  logic                  RD_PERR;
  logic                  RD_FERR;
  logic                  RD_BRK;
  logic                  FIFO_EMPTY;
  logic                  FIFO_FULL;
  logic                  OVERRUN;

  modport master (
    output RD_EN, CLR_OVR,
    input  RD_DATA, RD_PERR, RD_FERR, RD_BRK, FIFO_EMPTY, FIFO_FULL, OVERRUN
  );

  modport slave (
    input  RD_EN, CLR_OVR,
    output RD_DATA, RD_PERR, RD_FERR, RD_BRK, FIFO_EMPTY, FIFO_FULL, OVERRUN
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver feeding a first-word-fall-through receive FIFO.
// The receiver has runtime data length, optional parity, 1 or 2 stop bits,
// 3-sample majority voting, a 2-flop input synchroniser and break detection.
//   CLK, RST       : clock, asynchronous active-low reset
//   RX_IN          : asynchronous serial input (idles high)
//   Prescale       : clocks per bit (even, >= 8)
//   DATA_LEN       : data bits per frame (clamped into 5..MAX_DATA_W)
//   PAR_EN/PAR_TYP : parity enable / 0 = even, 1 = odd
//   STOP2          : two stop bits
//   rd_bus         : FIFO pop, overrun clear, head entry and status
module uart_rx_param #(
  parameter int MAX_DATA_W = 9,
  parameter int PRESC_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [3:0]         DATA_LEN,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  uart_rx_param_if.slave     rd_bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int ENT_W = MAX_DATA_W + 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len < 4'd5)                   return 4'd5;
    else if (len > 4'(MAX_DATA_W))    return 4'(MAX_DATA_W);
    else                              return len;
  endfunction

  function automatic logic parity_of(input logic [MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

  logic                  rx_meta_r, rx_sync_r, rx_s;
  state_t                state_r, state_nxt_s;
  logic [PRESC_W-1:0]    edge_cnt_r, presc_r, half_s;
  logic [3:0]            bit_cnt_r, len_r;
  logic                  par_en_r, par_typ_r, stop2_r, par_bit_r, ferr_r;
  logic [1:0]            samp_r;
  logic [MAX_DATA_W-1:0] shift_r;
  logic                  smp0_s, smp1_s, mid_s, last_edge_s, maj_s;
  logic                  enter_start_s, frame_done_s;
  logic                  ferr_s, perr_s, brk_s;
  logic [ENT_W-1:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  ovr_r, empty_s, full_s, rd_ok_s, wr_ok_s, ovr_set_s;
  logic [ENT_W-1:0]      head_s;

  assign rx_s        = rx_sync_r;
  assign half_s      = presc_r >> 1;
  assign smp0_s      = (edge_cnt_r == half_s - PRESC_W'(1));
  assign smp1_s      = (edge_cnt_r == half_s);
  assign mid_s       = (edge_cnt_r == half_s + PRESC_W'(1));
  assign last_edge_s = (edge_cnt_r == presc_r - PRESC_W'(1));
  // Third sample is the live one at the mid edge, so the vote is ready there.
  assign maj_s = (samp_r[0] & samp_r[1]) | (samp_r[0] & rx_s) | (samp_r[1] & rx_s);

  // Frame flags as they stand at the final stop-bit sample.
  assign ferr_s = ferr_r | ~maj_s;
  assign perr_s = par_en_r & (parity_of(shift_r) ^ par_bit_r ^ par_typ_r);
  assign brk_s  = ferr_s & (shift_r == {MAX_DATA_W{1'b0}}) & (~par_en_r | ~par_bit_r);

  // Two-flop synchroniser on the asynchronous serial input.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= RX_IN;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state and frame-event decode.
  always_comb begin
    state_nxt_s   = state_r;
    enter_start_s = 1'b0;
    frame_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nxt_s   = START;
          enter_start_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (mid_s && maj_s)   state_nxt_s = IDLE;
        else if (last_edge_s) state_nxt_s = DATA;
        else                  state_nxt_s = START;
      end
      DATA: begin
        if (last_edge_s && (bit_cnt_r == len_r - 4'd1)) state_nxt_s = par_en_r ? PARITY : STOP;
        else                                           state_nxt_s = DATA;
      end
      PARITY: begin
        if (last_edge_s) state_nxt_s = STOP;
        else             state_nxt_s = PARITY;
      end
      STOP: begin
        // Complete mid-way through the last stop bit to resync on the next start.
        if (mid_s && (!stop2_r || (bit_cnt_r == 4'd1))) begin
          state_nxt_s  = IDLE;
          frame_done_s = 1'b1;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Receiver state, counters, sample capture and per-frame configuration.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      edge_cnt_r <= {PRESC_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      presc_r    <= {PRESC_W{1'b0}};
      len_r      <= 4'd5;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      stop2_r    <= 1'b0;
      par_bit_r  <= 1'b0;
      ferr_r     <= 1'b0;
      samp_r     <= 2'b11;
      shift_r    <= {MAX_DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (smp0_s) samp_r[0] <= rx_s;
      if (smp1_s) samp_r[1] <= rx_s;
      if (enter_start_s) begin
        // The detecting cycle is edge 0, so the start bit continues at edge 1.
        edge_cnt_r <= PRESC_W'(1);
        bit_cnt_r  <= 4'd0;
        shift_r    <= {MAX_DATA_W{1'b0}};
        ferr_r     <= 1'b0;
        par_bit_r  <= 1'b0;
        presc_r    <= Prescale;
        len_r      <= clamp_len(DATA_LEN);
        par_en_r   <= PAR_EN;
        par_typ_r  <= PAR_TYP;
        stop2_r    <= STOP2;
      end else if (state_nxt_s == IDLE) begin
        edge_cnt_r <= {PRESC_W{1'b0}};
        bit_cnt_r  <= 4'd0;
      end else begin
        edge_cnt_r <= last_edge_s ? {PRESC_W{1'b0}} : edge_cnt_r + PRESC_W'(1);
        if (last_edge_s) bit_cnt_r <= (state_nxt_s != state_r) ? 4'd0 : bit_cnt_r + 4'd1;
        if (mid_s) begin
          case (state_r)
            DATA: begin
              for (int i = 0; i < MAX_DATA_W; i++) begin
                if (bit_cnt_r == 4'(i)) shift_r[i] <= maj_s;
              end
            end
            PARITY:  par_bit_r <= maj_s;
            STOP:    ferr_r    <= ferr_r | ~maj_s;
            default: ferr_r    <= ferr_r;
          endcase
        end
      end
    end
  end

  assign empty_s   = (count_r == CNT_W'(0));
  assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
  assign rd_ok_s   = rd_bus.RD_EN & ~empty_s;
  // A read in the same cycle frees the slot that a write into a full FIFO needs.
  assign wr_ok_s   = frame_done_s & (~full_s | rd_ok_s);
  assign ovr_set_s = frame_done_s & full_s & ~rd_bus.RD_EN;
  assign head_s    = mem_r[rd_ptr_r];

  // Receive FIFO storage, pointers, occupancy and sticky overrun.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {ENT_W{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovr_r    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= {brk_s, ferr_s, perr_s, shift_r};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      if (wr_ok_s && !rd_ok_s)      count_r <= count_r + CNT_W'(1);
      else if (rd_ok_s && !wr_ok_s) count_r <= count_r - CNT_W'(1);
      if (ovr_set_s)                ovr_r <= 1'b1;
      else if (rd_bus.CLR_OVR)      ovr_r <= 1'b0;
    end
  end

  // Head entry falls through; an empty FIFO reads as zero.
  assign rd_bus.RD_DATA    = empty_s ? {MAX_DATA_W{1'b0}} : head_s[MAX_DATA_W-1:0];
  assign rd_bus.RD_PERR    = ~empty_s & head_s[MAX_DATA_W];
  assign rd_bus.RD_FERR    = ~empty_s & head_s[MAX_DATA_W+1];
  assign rd_bus.RD_BRK     = ~empty_s & head_s[MAX_DATA_W+2];
  assign rd_bus.FIFO_EMPTY = empty_s;
  assign rd_bus.FIFO_FULL  = full_s;
  assign rd_bus.OVERRUN    = ovr_r;
endmodule
